// File: rtl/rf_operand_fetch.sv
// Operand-fetch initiator: issues rs/rt reads, latches A/B and hands them to the ALU stage.
// Optional RF_OPERAND_FWD_EN: forward/snoop register-file writes into the held operands.
module rf_operand_fetch #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [31:0]   instr,
  output logic [AW-1:0] ra1,
  output logic [AW-1:0] ra2,
  input  logic [DW-1:0] rd1,
  input  logic [DW-1:0] rd2,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] a_out,
  output logic [DW-1:0] b_out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] fetch_cnt
);

  typedef enum logic [1:0] {IDLE, READ, HOLD} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   rs_q, rt_q;
  logic [DW-1:0]   a_q, b_q, a_cap, b_cap;
  logic [CW-1:0]   cnt_q;
  logic            accept, capture, done;

  wire [AW-1:0] rs_in = instr[21 +: AW];
  wire [AW-1:0] rt_in = instr[16 +: AW];

  logic unused_instr;
  assign unused_instr = ^{instr[31:26], instr[15:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = READ;
      READ:    state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        accept    = req_valid;
      end
      READ: capture = 1'b1;
      HOLD: begin
        out_valid = 1'b1;
        done      = out_ready;
      end
      default: ;
    endcase
  end

`ifdef RF_OPERAND_FWD_EN
  // Register 0 never matches, so writes to it can't leak into an operand.
  logic snoop_a, snoop_b, hold_upd;
  assign snoop_a  = wr_en && (wr_addr == rs_q) && (rs_q != '0);
  assign snoop_b  = wr_en && (wr_addr == rt_q) && (rt_q != '0);
  assign hold_upd = (state == HOLD) && !out_ready;
  assign a_cap    = (rs_q == '0) ? '0 : (snoop_a ? wr_data : rd1);
  assign b_cap    = (rt_q == '0) ? '0 : (snoop_b ? wr_data : rd2);
`else
  logic unused_wr;
  assign unused_wr = ^{wr_en, wr_addr, wr_data};
  assign a_cap     = (rs_q == '0) ? '0 : rd1;
  assign b_cap     = (rt_q == '0) ? '0 : rd2;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs_q  <= '0;
      rt_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      cnt_q <= '0;
    end else begin
      if (accept) begin
        rs_q <= rs_in;
        rt_q <= rt_in;
      end
      if (capture) begin
        a_q <= a_cap;
        b_q <= b_cap;
      end
`ifdef RF_OPERAND_FWD_EN
      // A write racing the handshake is dropped: the consumer already took the old value.
      else if (hold_upd) begin
        if (snoop_a) a_q <= wr_data;
        if (snoop_b) b_q <= wr_data;
      end
`endif
      if (done) cnt_q <= cnt_q + CW'(1);
    end
  end

  assign ra1       = rs_q;
  assign ra2       = rt_q;
  assign a_out     = a_q;
  assign b_out     = b_q;
  assign fetch_cnt = cnt_q;

endmodule
